// File: rtl/tick_period_monitor.sv
// Measures clock-cycle spacing between rising edges of a periodic tick, flags periods
// outside EXP_MOD +/- TOL, declares lock after LOCK_CNT good periods and times out on silence.
//
// state      | meaning
// IDLE       | monitor disabled, counters cleared
// WAIT_FIRST | waiting for the edge that arms a measurement (no period reported)
// MEASURE    | counting cycles since the last edge; each edge reports a period
module tick_period_monitor #(
    parameter int MAX_COUNT = 1023,
    parameter int EXP_MOD   = 255,
    parameter int TOL       = 2,
    parameter int LOCK_CNT  = 4,
    localparam int CW       = $clog2(MAX_COUNT + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          tick,
    output logic [CW-1:0] period,
    output logic          period_valid,
    output logic          err,
    output logic          timeout,
    output logic          locked
);

    localparam int MW = $clog2(LOCK_CNT + 1);

    // Tolerance window is held one bit wider than the counter so EXP_MOD+TOL cannot wrap.
    localparam logic [CW:0]   LO_BOUND = (EXP_MOD > TOL) ? (CW+1)'(EXP_MOD - TOL) : '0;
    localparam logic [CW:0]   HI_BOUND = (CW+1)'(EXP_MOD + TOL);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_COUNT - 1);
    localparam logic [MW:0]   LOCK_SAT = (MW+1)'(LOCK_CNT);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        MEASURE    = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [MW-1:0] match_cnt;
    logic          tick_q;

    logic          rise;
    logic [CW:0]   period_new;
    logic          match;
    logic [MW:0]   mc_inc;

    assign rise       = tick & ~tick_q;
    assign period_new = {1'b0, cnt} + (CW+1)'(1);
    assign match      = (period_new >= LO_BOUND) && (period_new <= HI_BOUND);
    assign mc_inc     = {1'b0, match_cnt} + (MW+1)'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            match_cnt    <= '0;
            tick_q       <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            err          <= 1'b0;
            timeout      <= 1'b0;
            locked       <= 1'b0;
        end else begin
            tick_q       <= tick;
            period_valid <= 1'b0;
            err          <= 1'b0;
            timeout      <= 1'b0;

            // Disable overrides any edge or timeout seen on the same cycle.
            if (!enable) begin
                state     <= IDLE;
                cnt       <= '0;
                match_cnt <= '0;
                locked    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= WAIT_FIRST;
                    end
                    WAIT_FIRST: begin
                        if (rise) begin
                            state <= MEASURE;
                            cnt   <= '0;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            period       <= period_new[CW-1:0];
                            period_valid <= 1'b1;
                            cnt          <= '0;
                            if (match) begin
                                match_cnt <= (mc_inc >= LOCK_SAT) ? LOCK_SAT[MW-1:0]
                                                                  : mc_inc[MW-1:0];
                                locked    <= (mc_inc >= LOCK_SAT);
                            end else begin
                                err       <= 1'b1;
                                match_cnt <= '0;
                                locked    <= 1'b0;
                            end
                        end else if (cnt == CNT_LAST) begin
                            timeout   <= 1'b1;
                            match_cnt <= '0;
                            locked    <= 1'b0;
                            cnt       <= '0;
                            state     <= WAIT_FIRST;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tick_period_monitor.sv
// Directed bench for tick_period_monitor: a table of tick spacings with hand-computed
// period/err/locked results, plus sequences for timeout, async reset and disable.
module tb_tick_period_monitor;

    localparam int CW = 10;

    logic          clk;
    logic          reset_n;
    logic          enable;
    logic          tick;
    logic [CW-1:0] period;
    logic          period_valid;
    logic          err;
    logic          timeout;
    logic          locked;

    tick_period_monitor dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .tick         (tick),
        .period       (period),
        .period_valid (period_valid),
        .err          (err),
        .timeout      (timeout),
        .locked       (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int gap;
        int hold;
        bit valid;
        int per;
        bit err;
        bit lck;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs[NVEC];

    int n_cmp = 0;
    int n_bad = 0;
    int elapsed = 0;
    int spur = 0;

    logic          cap_valid;
    logic [CW-1:0] cap_period;
    logic          cap_err;
    logic          cap_timeout;
    logic          cap_locked;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step while counting any pulse that should not occur between expected edges.
    task automatic step_mon();
        step();
        if (period_valid || timeout) spur++;
    endtask

    // Rising edge sampled exactly 'gap' cycles after the previous one; tick stays high 'hold' cycles.
    task automatic send_tick(input int gap, input int hold, input bit en);
        spur = 0;
        repeat (gap - 1 - elapsed) step_mon();
        tick = 1'b1;
        enable = en;
        step();
        cap_valid   = period_valid;
        cap_period  = period;
        cap_err     = err;
        cap_timeout = timeout;
        cap_locked  = locked;
        repeat (hold - 1) step_mon();
        tick = 1'b0;
        elapsed = hold - 1;
    endtask

    task automatic check_cap(input string tag, input bit v, input int p, input bit e, input bit l);
        check({tag, "_valid"},   32'(cap_valid),   32'(v));
        check({tag, "_period"},  32'(cap_period),  p);
        check({tag, "_err"},     32'(cap_err),     32'(e));
        check({tag, "_locked"},  32'(cap_locked),  32'(l));
        check({tag, "_timeout"}, 32'(cap_timeout), 32'd0);
        check({tag, "_spurious"}, spur, 0);
    endtask

    initial begin
        vecs[0]  = '{5,    1,  1'b0, 0,    1'b0, 1'b0};
        vecs[1]  = '{255,  1,  1'b1, 255,  1'b0, 1'b0};
        vecs[2]  = '{255,  1,  1'b1, 255,  1'b0, 1'b0};
        vecs[3]  = '{255,  1,  1'b1, 255,  1'b0, 1'b0};
        vecs[4]  = '{255,  1,  1'b1, 255,  1'b0, 1'b1};
        vecs[5]  = '{256,  1,  1'b1, 256,  1'b0, 1'b1};
        vecs[6]  = '{257,  1,  1'b1, 257,  1'b0, 1'b1};
        vecs[7]  = '{259,  1,  1'b1, 259,  1'b1, 1'b0};
        vecs[8]  = '{253,  1,  1'b1, 253,  1'b0, 1'b0};
        vecs[9]  = '{255,  1,  1'b1, 255,  1'b0, 1'b0};
        vecs[10] = '{255,  1,  1'b1, 255,  1'b0, 1'b0};
        vecs[11] = '{255,  1,  1'b1, 255,  1'b0, 1'b1};
        vecs[12] = '{252,  1,  1'b1, 252,  1'b1, 1'b0};
        vecs[13] = '{260,  1,  1'b1, 260,  1'b1, 1'b0};
        vecs[14] = '{260,  1,  1'b1, 260,  1'b1, 1'b0};
        vecs[15] = '{260,  1,  1'b1, 260,  1'b1, 1'b0};
        vecs[16] = '{1023, 10, 1'b1, 1023, 1'b1, 1'b0};
        vecs[17] = '{255,  1,  1'b1, 255,  1'b0, 1'b0};
        vecs[18] = '{255,  1,  1'b1, 255,  1'b0, 1'b0};
        vecs[19] = '{255,  1,  1'b1, 255,  1'b0, 1'b0};
        vecs[20] = '{255,  1,  1'b1, 255,  1'b0, 1'b1};

        reset_n = 1'b0;
        enable  = 1'b0;
        tick    = 1'b0;
        repeat (3) step();
        check("rst_period",  32'(period),       32'd0);
        check("rst_valid",   32'(period_valid), 32'd0);
        check("rst_err",     32'(err),          32'd0);
        check("rst_timeout", 32'(timeout),      32'd0);
        check("rst_locked",  32'(locked),       32'd0);

        reset_n = 1'b1;
        enable  = 1'b1;
        step();
        elapsed = 0;

        for (int i = 0; i < NVEC; i++) begin
            send_tick(vecs[i].gap, vecs[i].hold, 1'b1);
            check_cap($sformatf("v%0d", i), vecs[i].valid, vecs[i].per, vecs[i].err, vecs[i].lck);
        end

        // Ticks stop after lock: timeout lands 1023 cycles after the last edge.
        spur = 0;
        repeat (1022) step_mon();
        check("to_early_pulses", spur, 0);
        check("to_before",        32'(timeout), 32'd0);
        check("to_locked_before", 32'(locked),  32'd1);
        step();
        check("to_pulse",  32'(timeout),      32'd1);
        check("to_locked", 32'(locked),       32'd0);
        check("to_period", 32'(period),       32'd255);
        check("to_valid",  32'(period_valid), 32'd0);
        step();
        check("to_one_cycle", 32'(timeout), 32'd0);
        elapsed = 0;
        send_tick(5, 1, 1'b1);
        check_cap("to_rearm", 1'b0, 255, 1'b0, 1'b0);
        send_tick(255, 1, 1'b1);
        check_cap("to_next", 1'b1, 255, 1'b0, 1'b0);

        // Lock again, then pull reset asynchronously between clock edges.
        for (int i = 0; i < 3; i++) send_tick(255, 1, 1'b1);
        check("pre_rst_locked", 32'(cap_locked), 32'd1);
        step();
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_period",  32'(period),       32'd0);
        check("arst_locked",  32'(locked),       32'd0);
        check("arst_valid",   32'(period_valid), 32'd0);
        check("arst_err",     32'(err),          32'd0);
        check("arst_timeout", 32'(timeout),      32'd0);
        #1;
        reset_n = 1'b1;
        step();
        elapsed = 0;

        // Re-lock, then drop enable on the same cycle as an edge.
        send_tick(5, 1, 1'b1);
        check_cap("re_arm", 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_tick(255, 1, 1'b1);
        check_cap("re_lock", 1'b1, 255, 1'b0, 1'b1);
        send_tick(255, 1, 1'b0);
        check_cap("dis_edge", 1'b0, 255, 1'b0, 1'b0);
        enable = 1'b1;
        send_tick(5, 1, 1'b1);
        check_cap("en_arm", 1'b0, 255, 1'b0, 1'b0);
        send_tick(250, 1, 1'b1);
        check_cap("en_first", 1'b1, 250, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
